demux_2_buf: RTL and testbench
==============================

// Module: demux_2_buf
// PURPOSE
//  Registered 1-to-2 demultiplexer with per-channel buffering; inverse of the 2-input result mux.
//  Steers one 16-bit word stream to one of two consumers (e.g. ALU result -> reg-file write port / memory store path).
//  Valid/ready handshake on every side; each channel has its own small FIFO so one stalled consumer never corrupts the other.
// PARAMETERS
//  WIDTH  16  data word width in bits
//  DEPTH  2   entries per channel FIFO; power of 2, >= 2
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      producer offers in_data this cycle
//  in_ready     out  1      selected channel can accept this cycle
//  in_sel       in   1      0 -> channel 1, 1 -> channel 2 (same encoding as mux control)
//  in_data      in   WIDTH  word to route
//  out_1_valid  out  1      channel 1 head entry valid
//  out_1_ready  in   1      channel 1 consumer accepts head
//  out_1_data   out  WIDTH  channel 1 head word
//  out_2_valid  out  1      channel 2 head entry valid
//  out_2_ready  in   1      channel 2 consumer accepts head
//  out_2_data   out  WIDTH  channel 2 head word
// BEHAVIOUR
//  - Reset (rst_n low, async): all pointers/counts 0, out_*_valid 0, out_*_data 0, FIFO contents discarded;
//    in_ready = 1 once reset is released (both FIFOs empty). Reset mid-transfer drops all queued words.
//  - in_ready = !full(ch[in_sel]); combinational from in_sel and registered counts only. No bypass of a same-cycle pop.
//  - Push: in_valid && in_ready at edge -> word written to FIFO ch[in_sel]; other FIFO untouched.
//  - Latency: word pushed at edge k is visible on out_x_data with out_x_valid=1 after edge k (cycle k+1). No in->out combinational path.
//  - Pop: out_x_valid && out_x_ready at edge -> rd pointer x advances; next entry (if any) appears next cycle.
//  - Simultaneous push and pop on same channel: both occur; count unchanged; allowed at count==DEPTH only if not full
//    before the edge (full channel never accepts, even with a pop in the same cycle).
//  - Full: count==DEPTH -> in_ready=0 whenever in_sel selects that channel; in_data ignored.
//  - Empty: out_x_valid=0; out_x_ready ignored; out_x_data holds last head value (no X, no change).
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
//  - in_sel may change every cycle; only its value at the handshake edge matters. Word order preserved per channel.
//  - out_x_valid never deasserts without a pop; out_x_data stable while valid && !ready.
// CONFIGURATION
//  DEMUX_2_BUF_CNT_EN defined: adds outputs cnt_1, cnt_2 (out, 16 each) = count of words popped per channel;
//   reset to 0, +1 per pop, wrap 0xFFFF -> 0x0000. Also adds in clr_cnt (in, 1): synchronous clear, wins over same-cycle increment.
//  Undefined: ports cnt_1, cnt_2, clr_cnt absent; no counter logic.
// STRUCTURE
//  - Shared package: WORD_W=16, SEL_CH1=1'b0, SEL_CH2=1'b1, DEMUX_DEPTH default.
//  - Sub-module demux_2_fifo (WIDTH, DEPTH; clk, rst_n, push, pop, din, dout, full, empty); instantiated twice.
//  - Top: select decode, in_ready mux, valid/ready glue, optional counters.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 words queued on ch1 -> out_1_valid=0, out_1_data=0 at once; rst_n=1 -> in_ready=1.
//  2 Route: push 0x1234 sel=0, then 0xABCD sel=1 -> out_1_data=0x1234 valid cycle k+1; out_2_data=0xABCD cycle k+2; other valid stays 0.
//  3 Full: out_1_ready=0, push 0x0001,0x0002 sel=0 -> in_ready=0 for sel=0, still 1 for sel=1; push 0x0003 sel=1 accepted.
//  4 Backpressure order: fill ch2 with 0x0A,0x0B, release out_2_ready one cycle at a time -> 0x0A then 0x0B, data stable while stalled.
//  5 Push+pop same cycle at count=1 on ch1 -> count stays 1, next head = new word; at count=DEPTH push refused.
//  6 DEMUX_2_BUF_CNT_EN: preload cnt_1=0xFFFF via 65535 pops, one more pop -> cnt_1=0x0000; clr_cnt with pop -> 0.

Source files
------------

// File: rtl/demux_2_buf_pkg.sv
// demux_2_buf shared definitions.
// Word width, channel select encoding and default FIFO depth.
package demux_2_buf_pkg;
  localparam int   WORD_W      = 16;
  localparam logic SEL_CH1     = 1'b0;
  localparam logic SEL_CH2     = 1'b1;
  localparam int   DEMUX_DEPTH = 2;
endpackage

// File: rtl/demux_2_fifo.sv
// demux_2_fifo: small per-channel FIFO.
// Head word is held after the last pop so an empty output never changes.
module demux_2_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? last_q : mem_q[rd_ptr_q];

  // Next-state: write slot, pointer wrap, occupancy, held head word
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // State registers; reset discards all queued words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: rtl/demux_2_buf.sv
// demux_2_buf: registered 1-to-2 demux with a FIFO per channel.
// Optional pop counters enabled by DEMUX_2_BUF_CNT_EN.
module demux_2_buf
  import demux_2_buf_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [WIDTH-1:0] out_1_data,
  output logic             out_2_valid,
  input  logic             out_2_ready,
  output logic [WIDTH-1:0] out_2_data
`ifdef DEMUX_2_BUF_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [15:0]      cnt_1,
  output logic [15:0]      cnt_2
`endif
);
  logic sel_ch2;
  logic full_1, full_2;
  logic empty_1, empty_2;
  logic push_1, push_2;
  logic pop_1, pop_2;

  assign sel_ch2     = (in_sel == SEL_CH2);
  assign in_ready    = sel_ch2 ? !full_2 : !full_1;
  assign push_1      = in_valid && in_ready && !sel_ch2;
  assign push_2      = in_valid && in_ready && sel_ch2;
  assign out_1_valid = !empty_1;
  assign out_2_valid = !empty_2;
  assign pop_1       = out_1_valid && out_1_ready;
  assign pop_2       = out_2_valid && out_2_ready;

  demux_2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_1),
    .pop   (pop_1),
    .din   (in_data),
    .dout  (out_1_data),
    .full  (full_1),
    .empty (empty_1)
  );

  demux_2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_2 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_2),
    .pop   (pop_2),
    .din   (in_data),
    .dout  (out_2_data),
    .full  (full_2),
    .empty (empty_2)
  );

`ifdef DEMUX_2_BUF_CNT_EN
  logic [15:0] cnt_1_q, cnt_1_d;
  logic [15:0] cnt_2_q, cnt_2_d;

  assign cnt_1 = cnt_1_q;
  assign cnt_2 = cnt_2_q;

  // Pop counters: clear beats increment, natural 16-bit wrap
  always_comb begin
    cnt_1_d = cnt_1_q;
    cnt_2_d = cnt_2_q;
    if (clr_cnt) begin
      cnt_1_d = '0;
      cnt_2_d = '0;
    end else begin
      if (pop_1) cnt_1_d = cnt_1_q + 16'd1;
      if (pop_2) cnt_2_d = cnt_2_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_1_q <= '0;
      cnt_2_q <= '0;
    end else begin
      cnt_1_q <= cnt_1_d;
      cnt_2_q <= cnt_2_d;
    end
  end
`endif
endmodule

// File: tb/tb_demux_2_buf.sv
// tb_demux_2_buf: directed and random checks of demux_2_buf.
// Reference is a pair of queues plus last-popped words.
module tb_demux_2_buf;
  localparam int W = 16;
  localparam int D = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [W-1:0] in_data;
  logic         out_1_valid;
  logic         out_1_ready;
  logic [W-1:0] out_1_data;
  logic         out_2_valid;
  logic         out_2_ready;
  logic [W-1:0] out_2_data;
`ifdef DEMUX_2_BUF_CNT_EN
  logic         clr_cnt;
  logic [15:0]  cnt_1;
  logic [15:0]  cnt_2;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  logic [W-1:0] last1, last2;
  int           cm1, cm2;

  demux_2_buf #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .out_1_valid (out_1_valid),
    .out_1_ready (out_1_ready),
    .out_1_data  (out_1_data),
    .out_2_valid (out_2_valid),
    .out_2_ready (out_2_ready),
    .out_2_data  (out_2_data)
`ifdef DEMUX_2_BUF_CNT_EN
    ,
    .clr_cnt     (clr_cnt),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    cm1 = 0;
    cm2 = 0;
  endtask

  // One cycle: drive, compare against model, clock, update model
  task automatic step(input logic v, input logic s,
                      input logic [W-1:0] d,
                      input logic r1, input logic r2);
    logic         er;
    logic         ev1, ev2;
    logic [W-1:0] ed1, ed2;
    logic         h, p1, p2;
    in_valid    = v;
    in_sel      = s;
    in_data     = d;
    out_1_ready = r1;
    out_2_ready = r2;
    #1;
    er  = s ? (q2.size() < D) : (q1.size() < D);
    ev1 = q1.size() > 0;
    ev2 = q2.size() > 0;
    ed1 = ev1 ? q1[0] : last1;
    ed2 = ev2 ? q2[0] : last2;
    checks++;
    if (in_ready !== er) begin
      errors++;
      $display("FAIL in_ready got %b want %b", in_ready, er);
    end
    checks++;
    if (out_1_valid !== ev1) begin
      errors++;
      $display("FAIL out_1_valid got %b want %b", out_1_valid, ev1);
    end
    checks++;
    if (out_1_data !== ed1) begin
      errors++;
      $display("FAIL out_1_data got %h want %h", out_1_data, ed1);
    end
    checks++;
    if (out_2_valid !== ev2) begin
      errors++;
      $display("FAIL out_2_valid got %b want %b", out_2_valid, ev2);
    end
    checks++;
    if (out_2_data !== ed2) begin
      errors++;
      $display("FAIL out_2_data got %h want %h", out_2_data, ed2);
    end
`ifdef DEMUX_2_BUF_CNT_EN
    checks++;
    if (cnt_1 !== 16'(cm1)) begin
      errors++;
      $display("FAIL cnt_1 got %h want %h", cnt_1, 16'(cm1));
    end
    checks++;
    if (cnt_2 !== 16'(cm2)) begin
      errors++;
      $display("FAIL cnt_2 got %h want %h", cnt_2, 16'(cm2));
    end
`endif
    h  = v && er;
    p1 = ev1 && r1;
    p2 = ev2 && r2;
    @(posedge clk);
    if (p1) last1 = q1.pop_front();
    if (p2) last2 = q2.pop_front();
`ifdef DEMUX_2_BUF_CNT_EN
    if (clr_cnt) begin
      cm1 = 0;
      cm2 = 0;
    end else begin
      if (p1) cm1 = (cm1 + 1) % 65536;
      if (p2) cm2 = (cm2 + 1) % 65536;
    end
`endif
    if (h) begin
      if (s) q2.push_back(d);
      else   q1.push_back(d);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D + 1; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_1_valid !== 1'b0 || out_1_data !== '0) begin
      errors++;
      $display("FAIL reset_init v=%b d=%h want 0/0", out_1_valid, out_1_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_1_valid !== 1'b0 || out_1_data !== '0) begin
      errors++;
      $display("FAIL reset_mid v=%b d=%h want 0/0", out_1_valid, out_1_data);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_sel = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_route();
    step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (out_1_valid !== 1'b1 || out_1_data !== 16'h1234 || out_2_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_ch1 v1=%b d1=%h v2=%b want 1/1234/0",
               out_1_valid, out_1_data, out_2_valid);
    end
    step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0);
    checks++;
    if (out_2_valid !== 1'b1 || out_2_data !== 16'hABCD || out_1_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_ch2 v2=%b d2=%h v1=%b want 1/abcd/0",
               out_2_valid, out_2_data, out_1_valid);
    end
    drain();
  endtask

  task automatic test_full();
    step(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    in_sel = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_sel0 got %b want 0", in_ready);
    end
    in_sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_sel1 got %b want 1", in_ready);
    end
    step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
    checks++;
    if (out_2_valid !== 1'b1 || out_2_data !== 16'h0003) begin
      errors++;
      $display("FAIL full_ch2 v=%b d=%h want 1/0003", out_2_valid, out_2_data);
    end
    step(1'b1, 1'b0, 16'h0009, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out_1_valid !== 1'b0 || out_1_data !== 16'h0002) begin
      errors++;
      $display("FAIL full_refuse v=%b d=%h want 0/0002", out_1_valid, out_1_data);
    end
    drain();
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h000B, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (out_2_data !== 16'h000A) begin
        errors++;
        $display("FAIL bp_stall0 got %h want 000a", out_2_data);
      end
    end
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (out_2_valid !== 1'b1 || out_2_data !== 16'h000B) begin
      errors++;
      $display("FAIL bp_second v=%b d=%h want 1/000b", out_2_valid, out_2_data);
    end
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    checks++;
    if (out_2_valid !== 1'b0 || out_2_data !== 16'h000B) begin
      errors++;
      $display("FAIL bp_empty v=%b d=%h want 0/000b", out_2_valid, out_2_data);
    end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b0, 16'h0055, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0066, 1'b1, 1'b0);
    in_sel = 1'b0;
    #1;
    checks++;
    if (out_1_data !== 16'h0066 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_cnt1 d=%h rdy=%b want 0066/1", out_1_data, in_ready);
    end
    step(1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0088, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out_1_valid !== 1'b0 || out_1_data !== 16'h0077) begin
      errors++;
      $display("FAIL pp_full v=%b d=%h want 0/0077", out_1_valid, out_1_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) != 0));
    end
    drain();
  endtask

`ifdef DEMUX_2_BUF_CNT_EN
  task automatic test_cnt();
    clr_cnt = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    clr_cnt = 1'b0;
    for (int i = 0; i < 65536; i++) step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
    checks++;
    if (cnt_1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_max got %h want ffff", cnt_1);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (cnt_1 !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_wrap got %h want 0000", cnt_1);
    end
    step(1'b1, 1'b0, 16'h00C1, 1'b0, 1'b0);
    clr_cnt = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    clr_cnt = 1'b0;
    checks++;
    if (cnt_1 !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_clr got %h want 0000", cnt_1);
    end
  endtask
`endif

  initial begin
    in_valid    = 1'b0;
    in_sel      = 1'b0;
    in_data     = '0;
    out_1_ready = 1'b0;
    out_2_ready = 1'b0;
`ifdef DEMUX_2_BUF_CNT_EN
    clr_cnt     = 1'b0;
`endif
    test_reset();
    test_route();
    test_full();
    test_backpressure();
    test_push_pop();
    test_random();
`ifdef DEMUX_2_BUF_CNT_EN
    test_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
